// File: rtl/pkt_prio_queue.sv
// Sorted shift-register priority queue: slot[0] always holds the best entry,
// equal priorities leave in arrival order, optional eviction of the worst entry when full.
module pkt_prio_queue #(
    parameter int DWIDTH        = 32,
    parameter int PRIOR_WIDTH   = 8,
    parameter int DEPTH         = 16,
    parameter int MIN_FIRST     = 1,
    parameter int EVICT_ON_FULL = 0,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_en,
    input  logic [PRIOR_WIDTH-1:0]       in_prior,
    input  logic [DWIDTH-1:0]            in_data,
    output logic                         in_ready,
    input  logic                         out_en,
    output logic                         out_valid,
    output logic [PRIOR_WIDTH-1:0]       out_prior,
    output logic [DWIDTH-1:0]            out_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty,
    output logic [CNT_WIDTH-1:0]         drop_cnt
);

    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] DROP_ONE = CNT_WIDTH'(1);
    localparam logic EVICT_EN = (EVICT_ON_FULL != 0);

    // "a is strictly better than b" under the configured ordering
    function automatic logic better(input logic [PRIOR_WIDTH-1:0] a,
                                    input logic [PRIOR_WIDTH-1:0] b);
        if (MIN_FIRST != 0) begin
            return a < b;
        end else begin
            return a > b;
        end
    endfunction

    logic                   valid_r [DEPTH];
    logic [PRIOR_WIDTH-1:0] prior_r [DEPTH];
    logic [DWIDTH-1:0]      data_r  [DEPTH];

    logic                   base_valid_s [DEPTH];
    logic [PRIOR_WIDTH-1:0] base_prior_s [DEPTH];
    logic [DWIDTH-1:0]      base_data_s  [DEPTH];

    logic                   next_valid_s [DEPTH];
    logic [PRIOR_WIDTH-1:0] next_prior_s [DEPTH];
    logic [DWIDTH-1:0]      next_data_s  [DEPTH];

    logic [DEPTH-1:0]       keep_s;
    logic [CW-1:0]          count_r;
    logic [CW-1:0]          count_nxt_s;
    logic                   full_r;
    logic                   empty_r;
    logic [CNT_WIDTH-1:0]   drop_cnt_r;

    logic pop_s;
    logic evict_ok_s;
    logic ins_s;
    logic drop_s;

    assign pop_s      = out_en & valid_r[0];
    assign evict_ok_s = EVICT_EN & better(in_prior, prior_r[DEPTH-1]);
    assign ins_s      = in_en & (~full_r | pop_s | evict_ok_s);
    // Every arrival that meets a full queue without a pop costs a drop,
    // whether it was rejected or displaced the worst entry.
    assign drop_s     = in_en & full_r & ~pop_s;
    assign in_ready   = ~full_r | pop_s | EVICT_EN;

    // Array as seen after head removal; vacated tail slot reads as empty
    always_comb begin
        for (int i = 0; i < DEPTH-1; i++) begin
            if (pop_s) begin
                base_valid_s[i] = valid_r[i+1];
                base_prior_s[i] = prior_r[i+1];
                base_data_s[i]  = data_r[i+1];
            end else begin
                base_valid_s[i] = valid_r[i];
                base_prior_s[i] = prior_r[i];
                base_data_s[i]  = data_r[i];
            end
        end
        if (pop_s) begin
            base_valid_s[DEPTH-1] = 1'b0;
            base_prior_s[DEPTH-1] = '0;
            base_data_s[DEPTH-1]  = '0;
        end else begin
            base_valid_s[DEPTH-1] = valid_r[DEPTH-1];
            base_prior_s[DEPTH-1] = prior_r[DEPTH-1];
            base_data_s[DEPTH-1]  = data_r[DEPTH-1];
        end
    end

    // Entries that stay in place: valid and not beaten by the arrival
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            keep_s[i] = base_valid_s[i] & ~better(in_prior, base_prior_s[i]);
        end
    end

    // Insert the arrival at the first non-kept slot and shift the rest down
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            next_valid_s[i] = base_valid_s[i];
            next_prior_s[i] = base_prior_s[i];
            next_data_s[i]  = base_data_s[i];
        end
        if (ins_s) begin
            if (!keep_s[0]) begin
                next_valid_s[0] = 1'b1;
                next_prior_s[0] = in_prior;
                next_data_s[0]  = in_data;
            end else begin
                next_valid_s[0] = base_valid_s[0];
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (keep_s[i]) begin
                    next_valid_s[i] = base_valid_s[i];
                end else if (keep_s[i-1]) begin
                    next_valid_s[i] = 1'b1;
                    next_prior_s[i] = in_prior;
                    next_data_s[i]  = in_data;
                end else begin
                    next_valid_s[i] = base_valid_s[i-1];
                    next_prior_s[i] = base_prior_s[i-1];
                    next_data_s[i]  = base_data_s[i-1];
                end
            end
        end else begin
            next_valid_s[0] = base_valid_s[0];
        end
    end

    // Occupancy: an eviction replaces an entry, so a full queue never grows
    always_comb begin
        count_nxt_s = count_r;
        if (ins_s && !pop_s && !full_r) begin
            count_nxt_s = count_r + CNT_ONE;
        end else if (pop_s && !ins_s) begin
            count_nxt_s = count_r - CNT_ONE;
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Slot array register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_r[i] <= 1'b0;
                prior_r[i] <= '0;
                data_r[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_r[i] <= next_valid_s[i];
                prior_r[i] <= next_prior_s[i];
                data_r[i]  <= next_data_s[i];
            end
        end
    end

    // Occupancy flags and saturating drop counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_r    <= '0;
            full_r     <= 1'b0;
            empty_r    <= 1'b1;
            drop_cnt_r <= '0;
        end else begin
            count_r <= count_nxt_s;
            full_r  <= (count_nxt_s == CNT_FULL);
            empty_r <= (count_nxt_s == '0);
            if (drop_s && (drop_cnt_r != '1)) begin
                drop_cnt_r <= drop_cnt_r + DROP_ONE;
            end else begin
                drop_cnt_r <= drop_cnt_r;
            end
        end
    end

    assign out_valid = valid_r[0];
    assign out_prior = prior_r[0];
    assign out_data  = data_r[0];
    assign count     = count_r;
    assign full      = full_r;
    assign empty     = empty_r;
    assign drop_cnt  = drop_cnt_r;

endmodule

// File: tb/tb_pkt_prio_queue.sv
// Directed bench for pkt_prio_queue: one instance without eviction, one with.
module tb_pkt_prio_queue;

    localparam int DW = 32;
    localparam int PW = 8;
    localparam int DEPTH = 16;
    localparam int CW = $clog2(DEPTH+1);
    localparam int NW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [PW-1:0] in_prior = '0;
    logic [DW-1:0] in_data = '0;

    logic          in_en = 1'b0, out_en = 1'b0;
    logic          in_ready, out_valid, full, empty;
    logic [PW-1:0] out_prior;
    logic [DW-1:0] out_data;
    logic [CW-1:0] count;
    logic [NW-1:0] drop_cnt;

    logic          e_in_en = 1'b0, e_out_en = 1'b0;
    logic          e_in_ready, e_out_valid, e_full, e_empty;
    logic [PW-1:0] e_out_prior;
    logic [DW-1:0] e_out_data;
    logic [CW-1:0] e_count;
    logic [NW-1:0] e_drop_cnt;

    int total_cnt = 0;
    int pass_cnt  = 0;

    always #5 clk = ~clk;

    pkt_prio_queue #(.DWIDTH(DW), .PRIOR_WIDTH(PW), .DEPTH(DEPTH), .MIN_FIRST(1),
                     .EVICT_ON_FULL(0), .CNT_WIDTH(NW)) u_dut (
        .clk(clk), .rst(rst), .in_en(in_en), .in_prior(in_prior), .in_data(in_data),
        .in_ready(in_ready), .out_en(out_en), .out_valid(out_valid),
        .out_prior(out_prior), .out_data(out_data), .count(count), .full(full),
        .empty(empty), .drop_cnt(drop_cnt)
    );

    pkt_prio_queue #(.DWIDTH(DW), .PRIOR_WIDTH(PW), .DEPTH(DEPTH), .MIN_FIRST(1),
                     .EVICT_ON_FULL(1), .CNT_WIDTH(NW)) u_dut_e (
        .clk(clk), .rst(rst), .in_en(e_in_en), .in_prior(in_prior), .in_data(in_data),
        .in_ready(e_in_ready), .out_en(e_out_en), .out_valid(e_out_valid),
        .out_prior(e_out_prior), .out_data(e_out_data), .count(e_count), .full(e_full),
        .empty(e_empty), .drop_cnt(e_drop_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // inputs change 1 time unit after the rising edge; outputs are read there too
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [PW-1:0] p, input logic [DW-1:0] d);
        in_prior = p; in_data = d; in_en = 1'b1;
        step();
        in_en = 1'b0;
    endtask

    task automatic e_push(input logic [PW-1:0] p, input logic [DW-1:0] d);
        in_prior = p; in_data = d; e_in_en = 1'b1;
        step();
        e_in_en = 1'b0;
    endtask

    task automatic pop_chk(input string tag, input logic [PW-1:0] p, input logic [DW-1:0] d);
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_prior"}, 64'(out_prior), 64'(p));
        chk({tag, "_data"},  64'(out_data),  64'(d));
        out_en = 1'b1;
        step();
        out_en = 1'b0;
    endtask

    task automatic e_pop_chk(input string tag, input logic [PW-1:0] p, input logic [DW-1:0] d);
        chk({tag, "_valid"}, 64'(e_out_valid), 64'd1);
        chk({tag, "_prior"}, 64'(e_out_prior), 64'(p));
        chk({tag, "_data"},  64'(e_out_data),  64'(d));
        e_out_en = 1'b1;
        step();
        e_out_en = 1'b0;
    endtask

    initial begin
        // reset held for three cycles
        rst = 1'b0;
        repeat (3) step();
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_drop", 64'(drop_cnt), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd1);
        chk("rst_prior", 64'(out_prior), 64'd0);
        rst = 1'b1;
        step();

        // ordering, lowest first
        push(8'd20, 32'd1);
        chk("ord_first_head", 64'(out_prior), 64'd20);
        push(8'd17, 32'd2);
        push(8'd22, 32'd3);
        push(8'd16, 32'd4);
        push(8'd19, 32'd5);
        chk("ord_count", 64'(count), 64'd5);
        chk("ord_empty", 64'(empty), 64'd0);
        pop_chk("ord0", 8'd16, 32'd4);
        pop_chk("ord1", 8'd17, 32'd2);
        pop_chk("ord2", 8'd19, 32'd5);
        pop_chk("ord3", 8'd20, 32'd1);
        pop_chk("ord4", 8'd22, 32'd3);
        chk("ord_drained_valid", 64'(out_valid), 64'd0);
        chk("ord_drained_empty", 64'(empty), 64'd1);
        chk("ord_drained_count", 64'(count), 64'd0);

        // out_en on empty is ignored
        out_en = 1'b1;
        step();
        out_en = 1'b0;
        chk("empty_pop_count", 64'(count), 64'd0);

        // push into empty with out_en high is not popped; then FIFO tie-break
        out_en = 1'b1;
        push(8'd18, 32'hA);
        out_en = 1'b0;
        chk("pe_valid", 64'(out_valid), 64'd1);
        chk("pe_count", 64'(count), 64'd1);
        push(8'd18, 32'hB);
        push(8'd18, 32'hC);
        pop_chk("fifo0", 8'd18, 32'hA);
        pop_chk("fifo1", 8'd18, 32'hB);
        pop_chk("fifo2", 8'd18, 32'hC);
        chk("fifo_empty", 64'(empty), 64'd1);

        // fill to full: prio i+1, data 100+i
        for (int i = 0; i < DEPTH; i++) begin
            push(PW'(i + 1), DW'(100 + i));
        end
        chk("full_flag", 64'(full), 64'd1);
        chk("full_ready", 64'(in_ready), 64'd0);
        chk("full_count", 64'(count), 64'd16);
        chk("full_drop0", 64'(drop_cnt), 64'd0);
        push(8'd0, 32'hDEAD);
        chk("drop_cnt1", 64'(drop_cnt), 64'd1);
        chk("drop_count", 64'(count), 64'd16);
        chk("drop_head", 64'(out_prior), 64'd1);

        // simultaneous push and pop on a full queue
        in_prior = 8'd100; in_data = 32'hBEEF; in_en = 1'b1; out_en = 1'b1;
        #1;
        chk("pp_ready", 64'(in_ready), 64'd1);
        step();
        in_en = 1'b0; out_en = 1'b0;
        chk("pp_count", 64'(count), 64'd16);
        chk("pp_head_prior", 64'(out_prior), 64'd2);
        chk("pp_head_data", 64'(out_data), 64'd101);
        chk("pp_drop", 64'(drop_cnt), 64'd1);
        chk("pp_full", 64'(full), 64'd1);

        // eviction instance: full of prio 20, data 200+i
        for (int i = 0; i < DEPTH; i++) begin
            e_push(8'd20, DW'(200 + i));
        end
        chk("ev_full", 64'(e_full), 64'd1);
        chk("ev_ready", 64'(e_in_ready), 64'd1);
        e_push(8'd16, 32'h55);
        chk("ev_head_prior", 64'(e_out_prior), 64'd16);
        chk("ev_head_data", 64'(e_out_data), 64'h55);
        chk("ev_drop1", 64'(e_drop_cnt), 64'd1);
        chk("ev_count1", 64'(e_count), 64'd16);
        e_push(8'd25, 32'h66);
        chk("ev_drop2", 64'(e_drop_cnt), 64'd2);
        chk("ev_count2", 64'(e_count), 64'd16);
        chk("ev_head_kept", 64'(e_out_prior), 64'd16);
        e_pop_chk("ev_pop_head", 8'd16, 32'h55);
        // the newest 20 (data 215) was the one discarded
        for (int i = 0; i < DEPTH-1; i++) begin
            e_pop_chk($sformatf("ev_pop%0d", i), 8'd20, DW'(200 + i));
        end
        chk("ev_empty", 64'(e_empty), 64'd1);
        chk("ev_valid", 64'(e_out_valid), 64'd0);

        // mid-stream asynchronous reset, observed before any clock edge
        e_push(8'd7, 32'h77);
        rst = 1'b0;
        #1;
        chk("mrst_valid", 64'(out_valid), 64'd0);
        chk("mrst_prior", 64'(out_prior), 64'd0);
        chk("mrst_data", 64'(out_data), 64'd0);
        chk("mrst_count", 64'(count), 64'd0);
        chk("mrst_full", 64'(full), 64'd0);
        chk("mrst_empty", 64'(empty), 64'd1);
        chk("mrst_drop", 64'(drop_cnt), 64'd0);
        chk("mrst_ready", 64'(in_ready), 64'd1);
        chk("mrst_e_valid", 64'(e_out_valid), 64'd0);
        chk("mrst_e_drop", 64'(e_drop_cnt), 64'd0);
        step();
        rst = 1'b1;
        step();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
